output_frame_player: RTL and testbench

Consumer at the far end of the output path. It accepts frames made of a 42-bit display pattern plus a 14-bit id/duration word through a valid/ready handshake, buffering one frame ahead. Each frame's pattern is held on the display outputs for its programmed number of ticks, and completion is reported by id. It sits between the core's output stage and the physical display/actuator pins.

---
 rtl/output_frame_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/output_frame_player.sv | 162 ++++++++++++++++
 tb/tb_output_frame_player.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_frame_pkg.sv
// Shared definitions for the output frame player.
// Holds the default widths, the field positions inside the id/duration word
// and the player FSM state type.
package output_frame_pkg;

  localparam int unsigned BITS_W = 42;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DUR_W  = 10;

  // Field slices of idAndDurationIn.
  localparam int unsigned ID_MSB  = 13;
  localparam int unsigned ID_LSB  = 10;
  localparam int unsigned DUR_MSB = 9;
  localparam int unsigned DUR_LSB = 0;

  typedef enum logic {
    IDLE,
    PLAY
  } playerState_e;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV cycle counter that produces the duration tick.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, count returns to 0
//   clear  - synchronous clear, takes priority over enable
//   enable - advance the count this cycle
//   tick   - high for the one cycle whose edge wraps the count to 0
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Tick is combinational so the consumer acts on the same edge as the wrap.
  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/output_frame_player.sv
// Output frame player: accepts frames (pattern + id/duration) over a
// valid/ready handshake with one frame of look-ahead buffering, holds each
// pattern on the display outputs for duration x TICK_DIV cycles and reports
// completion (or discard of a zero-duration frame) by id.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   bitsIn            - pattern of the offered frame
//   idAndDurationIn   - {id, duration in ticks} of the offered frame
//   inValid / inReady - handshake; inReady is registered
//   bitsOut, activeId - pattern and id currently playing, 0 when idle
//   playing           - a frame is on the outputs
//   doneValid, doneId - one-cycle completion pulse and the id it refers to
module output_frame_player #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned BITS_W   = output_frame_pkg::BITS_W,
  parameter int unsigned ID_W     = output_frame_pkg::ID_W,
  parameter int unsigned DUR_W    = output_frame_pkg::DUR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS_W-1:0]     bitsIn,
  input  logic [ID_W+DUR_W-1:0] idAndDurationIn,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [BITS_W-1:0]     bitsOut,
  output logic [ID_W-1:0]       activeId,
  output logic                  playing,
  output logic                  doneValid,
  output logic [ID_W-1:0]       doneId
);

  import output_frame_pkg::*;

  playerState_e stateQ, stateD;

  logic              pendFullQ, pendFullD;
  logic [BITS_W-1:0] pendBitsQ;
  logic [ID_W-1:0]   pendIdQ;
  logic [DUR_W-1:0]  pendDurQ;

  logic [BITS_W-1:0] curBitsQ, curBitsD;
  logic [ID_W-1:0]   curIdQ, curIdD;
  logic [DUR_W-1:0]  remQ, remD;

  logic            doneValidD;
  logic [ID_W-1:0] doneIdD;

  logic accept;
  logic prescClear;
  logic prescEnable;
  logic tick;

  assign accept      = inValid && inReady;
  assign prescEnable = (stateQ == PLAY);

  assign bitsOut  = curBitsQ;
  assign activeId = curIdQ;
  assign playing  = (stateQ == PLAY);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) uPrescaler (
    .clk   (clk),
    .reset (reset),
    .clear (prescClear),
    .enable(prescEnable),
    .tick  (tick)
  );

  always_comb begin
    stateD     = stateQ;
    pendFullD  = pendFullQ;
    curBitsD   = curBitsQ;
    curIdD     = curIdQ;
    remD       = remQ;
    doneValidD = 1'b0;
    doneIdD    = doneId;
    prescClear = 1'b0;

    unique case (stateQ)
      IDLE: begin
        if (pendFullQ) begin
          pendFullD = 1'b0;
          if (pendDurQ == '0) begin
            // Zero-length frame never plays; report it straight away.
            doneValidD = 1'b1;
            doneIdD    = pendIdQ;
          end else begin
            curBitsD   = pendBitsQ;
            curIdD     = pendIdQ;
            remD       = pendDurQ;
            prescClear = 1'b1;
            stateD     = PLAY;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (remQ == DUR_W'(1)) begin
            doneValidD = 1'b1;
            doneIdD    = curIdQ;
            if (pendFullQ && (pendDurQ != '0)) begin
              // Seamless hand-over: next frame starts on the very next cycle.
              curBitsD   = pendBitsQ;
              curIdD     = pendIdQ;
              remD       = pendDurQ;
              prescClear = 1'b1;
              pendFullD  = 1'b0;
            end else begin
              stateD   = IDLE;
              curBitsD = '0;
              curIdD   = '0;
            end
          end else begin
            remD = remQ - DUR_W'(1);
          end
        end
      end
      default: stateD = IDLE;
    endcase

    // inReady is low while pending is full, so this never collides with a load.
    if (accept) begin
      pendFullD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ    <= IDLE;
      pendFullQ <= 1'b0;
      curBitsQ  <= '0;
      curIdQ    <= '0;
      remQ      <= '0;
      doneValid <= 1'b0;
      doneId    <= '0;
      inReady   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      pendFullQ <= pendFullD;
      curBitsQ  <= curBitsD;
      curIdQ    <= curIdD;
      remQ      <= remD;
      doneValid <= doneValidD;
      doneId    <= doneIdD;
      inReady   <= ~pendFullD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendBitsQ <= '0;
      pendIdQ   <= '0;
      pendDurQ  <= '0;
    end else if (accept) begin
      pendBitsQ <= bitsIn;
      pendIdQ   <= idAndDurationIn[ID_MSB:ID_LSB];
      pendDurQ  <= idAndDurationIn[DUR_MSB:DUR_LSB];
    end
  end

endmodule

// File: tb/tb_output_frame_player.sv
// Bench for output_frame_player with TICK_DIV=4: directed scenarios plus a
// randomized run, all compared cycle by cycle against a frame-level model.
module tb_output_frame_player;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [41:0] bitsIn = '0;
  logic [13:0] idAndDurationIn = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [41:0] bitsOut;
  logic [3:0]  activeId;
  logic        playing;
  logic        doneValid;
  logic [3:0]  doneId;

  int checks = 0;
  int failures = 0;

  output_frame_player #(
    .TICK_DIV(TD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bitsIn         (bitsIn),
    .idAndDurationIn(idAndDurationIn),
    .inValid        (inValid),
    .inReady        (inReady),
    .bitsOut        (bitsOut),
    .activeId       (activeId),
    .playing        (playing),
    .doneValid      (doneValid),
    .doneId         (doneId)
  );

  always #5 clk = ~clk;

  // Frame-level model: a one-deep pending slot and a countdown of the cycles
  // the current frame still has on the outputs.
  typedef struct packed {
    logic        ready;
    logic        playing;
    logic        doneValid;
    logic        pendFull;
    logic [41:0] bits;
    logic [41:0] pendBits;
    logic [3:0]  id;
    logic [3:0]  doneId;
    logic [3:0]  pendId;
    logic [9:0]  pendDur;
    logic [31:0] left;
  } model_t;

  model_t m;

  function automatic model_t modelNext(input model_t c, input logic v, input logic [41:0] b,
                                       input logic [13:0] w);
    model_t n;
    n = c;
    n.doneValid = 1'b0;
    if (c.playing) begin
      n.left = c.left - 1;
      if (n.left == 0) begin
        n.doneValid = 1'b1;
        n.doneId = c.id;
        if (c.pendFull && c.pendDur != 0) begin
          n.bits = c.pendBits;
          n.id = c.pendId;
          n.left = TD * c.pendDur;
          n.pendFull = 1'b0;
        end else begin
          n.playing = 1'b0;
          n.bits = '0;
          n.id = '0;
        end
      end
    end else if (c.pendFull) begin
      n.pendFull = 1'b0;
      if (c.pendDur == 0) begin
        n.doneValid = 1'b1;
        n.doneId = c.pendId;
      end else begin
        n.playing = 1'b1;
        n.bits = c.pendBits;
        n.id = c.pendId;
        n.left = TD * c.pendDur;
      end
    end
    if (v && c.ready) begin
      n.pendFull = 1'b1;
      n.pendBits = b;
      n.pendId = w[13:10];
      n.pendDur = w[9:0];
    end
    n.ready = !n.pendFull;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else m <= modelNext(m, inValid, bitsIn, idAndDurationIn);
  end

  logic [52:0] obsVec, expVec;
  assign obsVec = {bitsOut, activeId, playing, doneValid, doneId, inReady};
  assign expVec = {m.bits, m.id, m.playing, m.doneValid, m.doneId, m.ready};

  // Recorders of observed activity (read by the tests, never compared here).
  int cyc = 0;
  int playCnt = 0;
  int riseCnt = 0;
  logic prevPlaying = 1'b0;
  logic [3:0] doneIds[$];
  int doneCyc[$];
  logic [3:0] accIds[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && inValid && inReady === 1'b1) accIds.push_back(idAndDurationIn[13:10]);
  end

  always @(negedge clk) begin
    if (playing === 1'b1) playCnt <= playCnt + 1;
    if (playing === 1'b1 && prevPlaying !== 1'b1) riseCnt <= riseCnt + 1;
    prevPlaying <= playing;
    if (doneValid === 1'b1) begin
      doneIds.push_back(doneId);
      doneCyc.push_back(cyc);
    end
  end

  // Present one frame at a negedge and hold it until the edge that takes it.
  task automatic offer(input logic [41:0] b, input logic [3:0] id, input logic [9:0] dur);
    int k;
    k = 0;
    bitsIn = b;
    idAndDurationIn = {id, dur};
    inValid = 1'b1;
    while (!m.ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!m.ready) begin
      failures++;
      $display("FAIL offer_timeout id=%0d: ready never seen (got 0, want 1)", id);
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obsVec !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got %h want 0", obsVec);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b want 0", inReady);
    end
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || playing !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_release: got ready=%b playing=%b want 1 0", inReady, playing);
    end
  endtask

  task automatic test_single_frame();
    logic [41:0] pat;
    int pb, db, acc;
    pat = 42'h2AAAAAAAAAA;
    pb = playCnt;
    db = doneIds.size();
    offer(pat, 4'd5, 10'd3);
    acc = cyc;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL single_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
      checks++;
      if (playing === 1'b1 && (bitsOut !== pat || activeId !== 4'd5)) begin
        failures++;
        $display("FAIL single_pattern: got %h/%0d want %h/5", bitsOut, activeId, pat);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (playCnt - pb != 12) begin
      failures++;
      $display("FAIL single_play_len: got %0d want 12", playCnt - pb);
    end
    checks++;
    if (doneIds.size() - db != 1 || doneIds[db] !== 4'd5 || doneCyc[db] - acc != 13) begin
      failures++;
      $display("FAIL single_done: got n=%0d id=%0d at +%0d want n=1 id=5 at +13",
               doneIds.size() - db, doneIds[db], doneCyc[db] - acc);
    end
    checks++;
    if (bitsOut !== '0 || activeId !== '0) begin
      failures++;
      $display("FAIL single_clear: got %h/%0d want 0/0", bitsOut, activeId);
    end
  endtask

  task automatic test_back_to_back();
    int pb, rb, db;
    pb = playCnt;
    rb = riseCnt;
    db = doneIds.size();
    offer(42'h155_5555_5555, 4'd1, 10'd2);
    offer(42'h0F0_F0F0_F0F0, 4'd2, 10'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL b2b_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
    end
    #1;
    checks++;
    if (playCnt - pb != 12 || riseCnt - rb != 1) begin
      failures++;
      $display("FAIL b2b_continuous: got len=%0d rises=%0d want 12 1", playCnt - pb, riseCnt - rb);
    end
    checks++;
    if (doneIds.size() - db != 2 || doneIds[db] !== 4'd1 || doneIds[db+1] !== 4'd2 ||
        doneCyc[db+1] - doneCyc[db] != 4) begin
      failures++;
      $display("FAIL b2b_done: got n=%0d ids=%0d,%0d gap=%0d want 2 1,2 4", doneIds.size() - db,
               doneIds[db], doneIds[db+1], doneCyc[db+1] - doneCyc[db]);
    end
  endtask

  task automatic test_zero_duration();
    int pb, db, acc;
    pb = playCnt;
    db = doneIds.size();
    offer(42'h3FF_FFFF_FFFF, 4'd7, 10'd0);
    acc = cyc;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL zero_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (doneIds.size() - db != 1 || doneIds[db] !== 4'd7 || doneCyc[db] - acc != 1) begin
      failures++;
      $display("FAIL zero_done: got n=%0d id=%0d at +%0d want 1 7 +1", doneIds.size() - db,
               doneIds[db], doneCyc[db] - acc);
    end
    checks++;
    if (playCnt != pb) begin
      failures++;
      $display("FAIL zero_playing: got %0d cycles want 0", playCnt - pb);
    end
  endtask

  task automatic test_backpressure();
    int pb, rb, db, ab, k;
    logic sawLow;
    logic [41:0] pats[3];
    pats[0] = 42'h111_1111_1111;
    pats[1] = 42'h222_2222_2222;
    pats[2] = 42'h333_3333_3333;
    pb = playCnt;
    rb = riseCnt;
    db = doneIds.size();
    ab = accIds.size();
    sawLow = 1'b0;
    for (int i = 0; i < 100; i++) begin
      k = accIds.size() - ab;
      if (k >= 3) break;
      bitsIn = pats[k];
      idAndDurationIn = {4'(k + 1), 10'd2};
      inValid = 1'b1;
      if (inReady === 1'b0) sawLow = 1'b1;
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL bp_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
    end
    inValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL bp_drain c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
    end
    #1;
    checks++;
    if (accIds.size() - ab != 3 || accIds[ab] !== 4'd1 || accIds[ab+1] !== 4'd2 ||
        accIds[ab+2] !== 4'd3 || !sawLow) begin
      failures++;
      $display("FAIL bp_accept: got n=%0d sawLow=%b want n=3 ids 1,2,3 sawLow=1",
               accIds.size() - ab, sawLow);
    end
    checks++;
    if (doneIds.size() - db != 3 || doneIds[db] !== 4'd1 || doneIds[db+1] !== 4'd2 ||
        doneIds[db+2] !== 4'd3) begin
      failures++;
      $display("FAIL bp_order: got n=%0d want 3 frames in order 1,2,3", doneIds.size() - db);
    end
    checks++;
    if (playCnt - pb != 24 || riseCnt - rb != 1) begin
      failures++;
      $display("FAIL bp_play: got len=%0d rises=%0d want 24 1", playCnt - pb, riseCnt - rb);
    end
  endtask

  task automatic test_mid_frame_reset();
    int db, pb;
    offer(42'h0AB_CDEF_0123, 4'd4, 10'd3);
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obsVec !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", obsVec);
    end
    db = doneIds.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL after_reset c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
    end
    #1;
    checks++;
    if (doneIds.size() != db) begin
      failures++;
      $display("FAIL reset_no_done: got %0d pulses want 0", doneIds.size() - db);
    end
    pb = playCnt;
    offer(42'h1234_5678_9A, 4'd9, 10'd1);
    for (int i = 0; i < 8; i++) @(negedge clk);
    #1;
    checks++;
    if (doneIds.size() - db != 1 || doneIds[db] !== 4'd9 || playCnt - pb != 4) begin
      failures++;
      $display("FAIL reset_recover: got n=%0d id=%0d len=%0d want 1 9 4", doneIds.size() - db,
               doneIds[db], playCnt - pb);
    end
  endtask

  task automatic test_max_duration();
    int db, acc, k;
    db = doneIds.size();
    offer(42'h2DE_ADBE_EF00, 4'd3, 10'd1023);
    acc = cyc;
    k = 0;
    while (doneIds.size() == db && k < 5000) begin
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL max_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (doneIds.size() - db != 1 || doneIds[db] !== 4'd3 || doneCyc[db] - acc != 1 + 1023 * TD)
    begin
      failures++;
      $display("FAIL max_duration: got n=%0d id=%0d at +%0d want 1 3 +%0d", doneIds.size() - db,
               doneIds[db], doneCyc[db] - acc, 1 + 1023 * TD);
    end
  endtask

  task automatic test_random();
    int db, ab;
    logic [63:0] r;
    db = doneIds.size();
    ab = accIds.size();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL random_cycle c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
      r = {$urandom(), $urandom()};
      bitsIn = r[41:0];
      idAndDurationIn = {4'($urandom_range(0, 15)), 10'($urandom_range(0, 3))};
      inValid = ($urandom_range(0, 2) != 0);
    end
    inValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("FAIL random_drain c=%0d: got %h want %h", cyc, obsVec, expVec);
      end
    end
    #1;
    checks++;
    if (doneIds.size() - db != accIds.size() - ab || accIds.size() == ab) begin
      failures++;
      $display("FAIL random_count: got done=%0d want accepted=%0d (nonzero)",
               doneIds.size() - db, accIds.size() - ab);
    end else begin
      for (int i = 0; i < accIds.size() - ab; i++) begin
        checks++;
        if (doneIds[db+i] !== accIds[ab+i]) begin
          failures++;
          $display("FAIL random_order idx=%0d: got %0d want %0d", i, doneIds[db+i], accIds[ab+i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_zero_duration();
    test_backpressure();
    test_mid_frame_reset();
    test_max_duration();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
